fetch_pc_gen: RTL

- Parametrised next-generation front-end fetch PC generator. It sits between the instruction buffer, the branch/redirect unit and the memory channel arbiter.
- Issues block-aligned fetch requests with up to MAX_OUTSTANDING requests in flight, advancing the PC by one fetch block per accepted request.
- On redirect or interrupt, marks in-flight requests stale, drops their responses, and flushes the instruction buffer.
- The memory channel returns fetch responses strictly in request order.

---
 rtl/fetch_pc_gen.sv | 110 +++++++++++
 1 files changed

// File: rtl/fetch_pc_gen.sv
// Front-end fetch PC generator: issues block-aligned fetch requests, tracks live/stale
// in-flight requests, and retargets on branch redirect or interrupt.
module fetch_pc_gen #(
    parameter int PC_W            = 48,
    parameter int BLOCK_BYTES     = 64,
    parameter int IDX_LO          = 3,
    parameter int IDX_W           = 19,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [PC_W-1:0]    boot_addr,
    input  logic               fetch_enable,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_target,
    input  logic               interrupt_valid,
    input  logic [PC_W-1:0]    interrupt_addr,
    output logic               req_valid,
    input  logic               req_ready,
    output logic [IDX_W-1:0]   req_index,
    output logic [PC_W-1:0]    req_pc,
    input  logic               resp_valid,
    output logic               resp_accept,
    output logic               resp_drop,
    output logic               clear_ibuffer,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   inflight
);

    localparam logic [PC_W-1:0]  BLOCK_SZ   = PC_W'(BLOCK_BYTES);
    localparam logic [PC_W-1:0]  ALIGN_MASK = ~(BLOCK_SZ - PC_W'(1));
    localparam logic [CNT_W:0]   MAX_OUT    = (CNT_W+1)'(MAX_OUTSTANDING);

    // Align down first so an unaligned redirect target advances to the next boundary.
    function automatic logic [PC_W-1:0] next_block(input logic [PC_W-1:0] p);
        return (p & ALIGN_MASK) + BLOCK_SZ;
    endfunction

    logic [CNT_W-1:0] live_cnt;
    logic [CNT_W-1:0] stale_cnt;

    logic              fire;
    logic              redir;
    logic [PC_W-1:0]   redir_pc;
    logic              stale_hit;
    logic              issue;
    logic [CNT_W:0]    occupancy;
    logic [CNT_W:0]    redir_stale;

    logic [PC_W-1:0]   pc_nxt;
    logic              req_valid_nxt;
    logic [CNT_W-1:0]  live_nxt;
    logic [CNT_W-1:0]  stale_nxt;

    assign fire      = req_valid & req_ready;
    assign redir     = interrupt_valid | redirect_valid;
    assign redir_pc  = interrupt_valid ? interrupt_addr : redirect_target;

    // Responses are classified against the pre-redirect counters; stale ones drain first.
    assign stale_hit   = resp_valid & (stale_cnt != '0);
    assign resp_accept = resp_valid & (stale_cnt == '0) & (live_cnt != '0);
    assign resp_drop   = resp_valid & ~resp_accept;

    assign occupancy   = {1'b0, live_cnt} + {1'b0, stale_cnt} + (CNT_W+1)'(fire);
    assign issue       = (~req_valid | fire) & fetch_enable & ~redir & (occupancy < MAX_OUT);
    assign redir_stale = occupancy - (CNT_W+1)'(stale_hit | resp_accept);

    assign req_pc    = pc;
    assign req_index = pc[IDX_LO +: IDX_W];
    assign inflight  = live_cnt + stale_cnt;

    always_comb begin
        pc_nxt        = pc;
        req_valid_nxt = req_valid;
        live_nxt      = live_cnt;
        stale_nxt     = stale_cnt;
        if (redir) begin
            // A pending request survives and picks up the new target; an accepted one goes stale.
            pc_nxt        = redir_pc;
            req_valid_nxt = req_valid & ~req_ready;
            live_nxt      = '0;
            stale_nxt     = CNT_W'(redir_stale);
        end else begin
            if (fire) begin
                pc_nxt = next_block(pc);
            end
            req_valid_nxt = issue | (req_valid & ~req_ready);
            live_nxt      = live_cnt + CNT_W'(fire) - CNT_W'(resp_accept);
            stale_nxt     = stale_cnt - CNT_W'(stale_hit);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc            <= boot_addr;
            req_valid     <= 1'b0;
            clear_ibuffer <= 1'b0;
            live_cnt      <= '0;
            stale_cnt     <= '0;
        end else begin
            pc            <= pc_nxt;
            req_valid     <= req_valid_nxt;
            clear_ibuffer <= redir;
            live_cnt      <= live_nxt;
            stale_cnt     <= stale_nxt;
        end
    end

endmodule
